// File: rtl/ether_pkg.sv
// Shared Ethernet TX/RX definitions: arbiter state encoding and frame timing constants.
package ether_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_XFER,
        TX_IFG
    } tx_arb_state_t;

    // 96 bit times of inter-frame gap and 1518-byte frames, both in RMII dibits
    localparam int unsigned ETH_IFG_DIBITS = 48;
    localparam int unsigned ETH_MAX_DIBITS = 6072;
    localparam int unsigned DIBIT_W        = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping mod N.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ether_tx_arb.sv
// Frame-atomic round-robin arbiter sharing the RMII TX dibit path between N_REQ sources,
// enforcing the inter-frame gap and maximum frame length.
module ether_tx_arb
    import ether_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned IFG_DIBITS = ETH_IFG_DIBITS,
    parameter int unsigned MAX_DIBITS = ETH_MAX_DIBITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_axiiv,
    input  logic [2*N_REQ-1:0]   req_axiid,
    input  logic [N_REQ-1:0]     req_axiilast,
    output logic [N_REQ-1:0]     req_axiiready,
    output logic                 axiov,
    output logic [1:0]           axiod,
    output logic                 axiolast,
    output logic                 axioerr,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned LEN_W = $clog2(MAX_DIBITS + 1);
    localparam int unsigned IFG_W = $clog2(IFG_DIBITS + 1);

    tx_arb_state_t      state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic               axiov_q, axiov_d;
    logic [1:0]         axiod_q, axiod_d;
    logic               axiolast_q, axiolast_d;
    logic               axioerr_q, axioerr_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_v;
    logic               sel_last;
    logic [1:0]         sel_data;
    logic               at_max;

    rr_pick #(.N(N_REQ)) u_pick (
        .req (req_axiiv),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // ptr holds the current/last winner, so it doubles as the data mux select
    assign sel_v    = req_axiiv[ptr_q];
    assign sel_last = req_axiilast[ptr_q];
    assign sel_data = req_axiid[{ptr_q, 1'b0} +: 2];
    assign at_max   = (len_q == LEN_W'(MAX_DIBITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            len_q      <= '0;
            ifg_q      <= '0;
            axiov_q    <= 1'b0;
            axiod_q    <= '0;
            axiolast_q <= 1'b0;
            axioerr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            ifg_q      <= ifg_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            axiolast_q <= axiolast_d;
            axioerr_q  <= axioerr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        ifg_d         = ifg_q;
        axiov_d       = 1'b0;
        axiod_d       = '0;
        axiolast_d    = 1'b0;
        axioerr_d     = 1'b0;
        req_axiiready = '0;

        unique case (state_q)
            TX_IDLE: begin
                if (|req_axiiv) begin
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                    len_d   = '0;
                    state_d = TX_XFER;
                end
            end
            TX_XFER: begin
                // A full-length frame refuses one more dibit; the remainder re-arbitrates later
                if (!at_max) begin
                    req_axiiready = grant_q;
                end
                if (sel_v && !at_max) begin
                    axiov_d    = 1'b1;
                    axiod_d    = sel_data;
                    axiolast_d = sel_last;
                    len_d      = len_q + LEN_W'(1);
                    if (sel_last) begin
                        state_d = TX_IFG;
                        ifg_d   = '0;
                        grant_d = '0;
                    end
                end else begin
                    axioerr_d = 1'b1;
                    state_d   = TX_IFG;
                    ifg_d     = '0;
                    grant_d   = '0;
                end
            end
            TX_IFG: begin
                if (ifg_q == IFG_W'(IFG_DIBITS - 1)) begin
                    state_d = TX_IDLE;
                end else begin
                    ifg_d = ifg_q + IFG_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    assign grant    = grant_q;
    assign axiov    = axiov_q;
    assign axiod    = axiod_q;
    assign axiolast = axiolast_q;
    assign axioerr  = axioerr_q;
    assign busy     = (state_q != TX_IDLE);

endmodule

// File: tb/tb_ether_tx_arb.sv
// Scoreboard bench for ether_tx_arb: a frame-level round-robin model predicts the output stream.
module tb_ether_tx_arb;

    localparam int N    = 2;
    localparam int IFG  = 4;
    localparam int MAXD = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   v, ll, ready, grant;
    logic [2*N-1:0] dd;
    logic           axiov, axiolast, axioerr, busy;
    logic [1:0]     axiod;

    typedef struct {
        logic [1:0] d;
        bit         last;
        bit         drop;
    } item_t;

    typedef struct {
        bit         err;
        logic [1:0] d;
        bit         last;
        int         req;
        bit         gap;
    } exp_t;

    item_t drv_q [N][$];
    item_t mq    [N][$];
    exp_t  exp_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int end_cyc     = -1000;
    bit mon_en      = 1'b0;
    int mp          = N - 1;
    int acc_cnt [N];

    always #5 clk = ~clk;

    ether_tx_arb #(
        .N_REQ      (N),
        .IFG_DIBITS (IFG),
        .MAX_DIBITS (MAXD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_axiiv     (v),
        .req_axiid     (dd),
        .req_axiilast  (ll),
        .req_axiiready (ready),
        .axiov         (axiov),
        .axiod         (axiod),
        .axiolast      (axiolast),
        .axioerr       (axioerr),
        .grant         (grant),
        .busy          (busy)
    );

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Queue one frame on requester r; drop_at>0 makes it an underrun after drop_at dibits
    task automatic add_frame(input int r, input int n, input int drop_at, input bit rnd);
        item_t it;
        int    cnt;
        cnt = (drop_at != 0) ? drop_at : n;
        for (int k = 0; k < cnt; k++) begin
            it.d    = rnd ? 2'($urandom_range(0, 3)) : 2'(3 - (k % 4));
            it.last = (drop_at == 0) && (k == n - 1);
            it.drop = (drop_at != 0) && (k == drop_at - 1);
            drv_q[r].push_back(it);
            mq[r].push_back(it);
        end
    endtask

    // Frame-level reference: round-robin over requesters with pending dibits, frames cut at MAXD
    task automatic run_model();
        bit    first;
        int    r, cnt;
        item_t it;
        exp_t  e;
        first = 1'b1;
        forever begin
            r = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mp + k) % N;
                if (r < 0 && mq[c].size() > 0) r = c;
            end
            if (r < 0) break;
            mp  = r;
            cnt = 0;
            forever begin
                if (cnt == MAXD) begin
                    e = '{err: 1'b1, d: 2'b00, last: 1'b0, req: r, gap: 1'b0};
                    exp_q.push_back(e);
                    break;
                end
                it = mq[r].pop_front();
                e  = '{err: 1'b0, d: it.d, last: it.last, req: r, gap: (!first && cnt == 0)};
                exp_q.push_back(e);
                cnt++;
                if (it.last) break;
                if (it.drop) begin
                    e = '{err: 1'b1, d: 2'b00, last: 1'b0, req: r, gap: 1'b0};
                    exp_q.push_back(e);
                    break;
                end
            end
            first = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || busy || drv_q[0].size() > 0 || drv_q[1].size() > 0) && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", int'(t >= 3000), 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_axiov"}, int'(axiov), 0);
        chk({tag, "_axiod"}, int'(axiod), 0);
        chk({tag, "_axiolast"}, int'(axiolast), 0);
        chk({tag, "_axioerr"}, int'(axioerr), 0);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(ready), 0);
    endtask

    // Start a req0 frame, reset after its 5th accepted dibit, and check everything clears
    task automatic mid_reset();
        int base, t;
        mon_en = 1'b0;
        add_frame(0, 8, 0, 1'b0);
        base = acc_cnt[0];
        t    = 0;
        while (acc_cnt[0] - base < 5 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("midframe_accept_timeout", int'(t >= 200), 0);
        rst = 1'b1;
        exp_q.delete();
        mq[0].delete();
        mq[1].delete();
        @(negedge clk);
        check_quiet("midrst");
        @(negedge clk);
        #1;
        rst     = 1'b0;
        mp      = N - 1;
        end_cyc = -1000;
        mon_en  = 1'b1;
    endtask

    task automatic monitor_step();
        exp_t e;
        chk("ready_onehot0", int'($onehot0(ready)), 1);
        chk("ready_outside_grant", int'(ready & ~grant), 0);
        chk("valid_with_err", int'(axiov & axioerr), 0);
        if (axiov) begin
            chk("data_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("kind_data", int'(e.err), 0);
                chk("axiod", int'(axiod), int'(e.d));
                chk("axiolast", int'(axiolast), int'(e.last));
                if (!axiolast) chk("grant_owner", int'(grant), 1 << e.req);
                if (e.gap) chk("ifg_gap", cyc - end_cyc - 1, IFG + 1);
            end
            if (axiolast) end_cyc = cyc;
        end else begin
            chk("axiod_idle", int'(axiod), 0);
            chk("axiolast_idle", int'(axiolast), 0);
        end
        if (axioerr) begin
            chk("err_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("kind_err", int'(e.err), 1);
            end
            end_cyc = cyc;
        end
        if (cyc == end_cyc + IFG - 1) chk("busy_in_ifg", int'(busy), 1);
        if (cyc == end_cyc + IFG) chk("busy_after_ifg", int'(busy), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst) monitor_step();
        end
    end

    // Requester drivers: present queue heads, pop on accept, idle one cycle after an underrun point
    initial begin
        logic [N-1:0] acc;
        bit           drop_p [N];
        item_t        it;
        v   = '0;
        dd  = '0;
        ll  = '0;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            drop_p[i]  = 1'b0;
            acc_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            acc = v & ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    drv_q[i].delete();
                    drop_p[i] = 1'b0;
                end else if (drop_p[i]) begin
                    drop_p[i] = 1'b0;
                end else if (acc[i] && drv_q[i].size() > 0) begin
                    it = drv_q[i].pop_front();
                    acc_cnt[i]++;
                    if (it.drop) drop_p[i] = 1'b1;
                end
                if (!rst && !drop_p[i] && drv_q[i].size() > 0) begin
                    v[i]          = 1'b1;
                    dd[2*i +: 2]  = drv_q[i][0].d;
                    ll[i]         = drv_q[i][0].last;
                end else begin
                    v[i]          = 1'b0;
                    dd[2*i +: 2]  = 2'b00;
                    ll[i]         = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, r, drop_at;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // both requesters valid together: req0, req1, req0, req1
        add_frame(0, 4, 0, 1'b1);
        add_frame(1, 4, 0, 1'b1);
        add_frame(0, 4, 0, 1'b1);
        add_frame(1, 4, 0, 1'b1);
        run_model();
        wait_drain();

        // single req0 frame 3,2,1,0,3,2,1,0
        add_frame(0, 8, 0, 1'b0);
        run_model();
        wait_drain();

        // req1 underrun after 3 of 6 dibits
        add_frame(1, 6, 3, 1'b0);
        run_model();
        wait_drain();

        // req0 oversize: 20 dibits split into 16+err and a 4-dibit re-arbitrated frame
        add_frame(0, 20, 0, 1'b0);
        run_model();
        wait_drain();

        // exactly MAXD dibits with last is legal
        add_frame(0, MAXD, 0, 1'b0);
        run_model();
        wait_drain();

        // randomized mix of lengths, owners, oversize and underruns
        for (int f = 0; f < 14; f++) begin
            r       = int'($urandom_range(0, N - 1));
            n       = int'($urandom_range(1, 24));
            drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (n < 12) ? n : 12)) : 0;
            add_frame(r, n, drop_at, 1'b1);
        end
        run_model();
        wait_drain();

        // reset while req0 owns the path: pointer returns to N-1, so req0 wins a tie
        mid_reset();
        add_frame(1, 4, 0, 1'b1);
        add_frame(0, 4, 0, 1'b1);
        run_model();
        wait_drain();

        // reset again; a lone req1 request is granted first
        mid_reset();
        add_frame(1, 5, 0, 1'b1);
        run_model();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
